decode_ctrl_stage: RTL and testbench
====================================

Name: decode_ctrl_stage

Overview:
- Registered, parametrised main-decode stage for the pipelined CPU. It decodes the opcode into datapath control and latches the result into the ID/EX control register.
- Adds opcodes for the FPU and crypto core. These are multicycle ops, and the stage holds them in its output register for MC_LAT cycles while stalling upstream.
- Supports downstream stall, flush and illegal-opcode flagging.

Parameters:
- OP_W, 4: opcode width; must be >= 4. Any nonzero bit above bit 3 marks the opcode illegal.
- MC_LAT, 4: occupancy in cycles of FPU/crypto ops; must be >= 1.
- CNT_W, $clog2(MC_LAT+1): derived localparam; width of the busy counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  op is a real instruction (else a bubble is captured)
- op  in  OP_W  opcode
- stall_in  in  1  downstream hazard; hold the register
- flush  in  1  kill the register contents (branch/jump redirect)
- stall_out  out  1  to IF/ID; combinational = stall_in | busy
- out_valid  out  1  registered control is a live instruction
- ALUop  out  2  registered
- resmux  out  2  registered; 11 selects FPU/crypto result
- ALUSrc, branch, memwrite, a2src, regwrite, jump  out  1 each  registered
- fpu_en, crypto_en  out  1 each  registered unit select
- mc_start  out  1  registered one-cycle pulse on the first cycle a multicycle op is in the register
- illegal  out  1  registered illegal-opcode flag

Behaviour:
- Decode table (combinational). Field order: ALUop, ALUSrc, branch, memwrite, a2src, regwrite, resmux, jump.
  - 0 R: 10,0,0,0,1,1,00,0
  - 1 L: 00,1,0,0,0,1,01,0
  - 2 S: 00,1,0,1,0,0,01,0
  - 3 I: 10,1,0,0,0,1,00,0
  - 4 B: 01,0,1,0,0,0,10,0
  - 5 J: 00,0,0,0,0,1,10,1
  - 6 F: 00,0,0,0,1,1,11,0 with fpu_en=1
  - 7 C: 00,0,0,0,1,1,11,0 with crypto_en=1
  - 8..15, or any upper bit set: all controls 0, illegal=1. Every unlisted enable is 0.
- Bubble value: all registered outputs 0, including out_valid and illegal.
- Reset (async, rst_n=0): all registered outputs = bubble value, FSM = IDLE, counter = 0. Reset mid-busy aborts the op. stall_out then equals stall_in.
- Update priority on each posedge:
  1. flush: load the bubble, FSM goes to IDLE, counter = 0.
  2. stall_in: hold all registers; counter frozen; mc_start forced 0.
  3. busy: hold the output register, decrement the counter, mc_start = 0. When the counter reaches 0, busy clears and the next edge captures normally.
  4. Otherwise: if in_valid, capture the decode with out_valid=1, else capture the bubble.
- Latency: 1 cycle, op to registered control.
- FSM states:
  - IDLE -> BUSY when an op 6/7 is captured and MC_LAT > 1. The counter loads MC_LAT-1 and mc_start=1 for that cycle.
  - BUSY -> IDLE when the counter is 1 and decrements to 0.
  - With MC_LAT=1 the FSM never leaves IDLE, but mc_start still pulses.
- Occupancy: a multicycle op sits in the register for exactly MC_LAT unstalled cycles. busy, and therefore stall_out, is high for MC_LAT-1 of them.
- Illegal op: captured with out_valid=1, illegal=1, and regwrite/memwrite/branch/jump=0. It never enters BUSY.
- flush and stall_in together: flush wins.
- Back-to-back F ops: the second op is held upstream by stall_out and captured on the edge after busy clears. There is no gap cycle beyond that.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode localparams OP_R..OP_C
  - ALUop encodings
  - resmux encodings RES_ALU=00, RES_MEM=01, RES_PC=10, RES_UNIT=11
  - a packed ctrl_t struct of all control fields, which the bubble constant and the register both use
- One sub-module, ctrl_decode_comb: a pure combinational table, op to ctrl_t plus illegal. The registered stage instantiates it.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with random inputs -> all outputs 0 immediately, stall_out=stall_in.
- Sweep ops 0..7 with in_valid=1, no stalls -> each appears one cycle later with exactly the table values and out_valid=1. Op 9 -> illegal=1 with regwrite/memwrite/branch/jump=0.
- Op 6, MC_LAT=4 -> mc_start is a single pulse; stall_out high for 3 cycles; register holds fpu_en=1, resmux=11 for 4 cycles. A queued op 0 is captured on cycle 5.
- Op 7, then stall_in=1 for 2 cycles during BUSY -> counter freezes; stall_out is high for 5 cycles total; crypto_en is held throughout.
- Flush in the second busy cycle of op 6 -> next cycle all outputs 0, stall_out=stall_in, FSM IDLE. A following op 3 is captured normally.
- flush=1 and stall_in=1 on the same edge while holding op 4 -> bubble loaded; with MC_LAT=1, op 6 gives mc_start with no stall_out.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the main-decode stage: opcodes, ALU/result
// selects and the packed control word carried in the ID/EX register.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_R = 4'd0;
  localparam logic [3:0] OP_L = 4'd1;
  localparam logic [3:0] OP_S = 4'd2;
  localparam logic [3:0] OP_I = 4'd3;
  localparam logic [3:0] OP_B = 4'd4;
  localparam logic [3:0] OP_J = 4'd5;
  localparam logic [3:0] OP_F = 4'd6;
  localparam logic [3:0] OP_C = 4'd7;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_PC   = 2'b10;
  localparam logic [1:0] RES_UNIT = 2'b11;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       branch;
    logic       memwrite;
    logic       a2src;
    logic       regwrite;
    logic [1:0] resmux;
    logic       jump;
    logic       fpu_en;
    logic       crypto_en;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic {S_IDLE, S_BUSY} mc_state_e;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational main-decode table: opcode to control word plus illegal flag.
module ctrl_decode_comb
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] op,
  output ctrl_t           ctrl,
  output logic            illegal
);

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    illegal = 1'b0;
    // bit 3 and above set means outside the 0..7 opcode space
    if (|op[OP_W-1:3]) begin
      illegal = 1'b1;
    end else begin
      case (op[2:0])
        OP_R[2:0]: begin
          ctrl.aluop = ALU_FN; ctrl.a2src = 1'b1; ctrl.regwrite = 1'b1;
          ctrl.resmux = RES_ALU;
        end
        OP_L[2:0]: begin
          ctrl.aluop = ALU_ADD; ctrl.alusrc = 1'b1; ctrl.regwrite = 1'b1;
          ctrl.resmux = RES_MEM;
        end
        OP_S[2:0]: begin
          ctrl.aluop = ALU_ADD; ctrl.alusrc = 1'b1; ctrl.memwrite = 1'b1;
          ctrl.resmux = RES_MEM;
        end
        OP_I[2:0]: begin
          ctrl.aluop = ALU_FN; ctrl.alusrc = 1'b1; ctrl.regwrite = 1'b1;
          ctrl.resmux = RES_ALU;
        end
        OP_B[2:0]: begin
          ctrl.aluop = ALU_BR; ctrl.branch = 1'b1; ctrl.resmux = RES_PC;
        end
        OP_J[2:0]: begin
          ctrl.regwrite = 1'b1; ctrl.resmux = RES_PC; ctrl.jump = 1'b1;
        end
        OP_F[2:0]: begin
          ctrl.a2src = 1'b1; ctrl.regwrite = 1'b1; ctrl.resmux = RES_UNIT;
          ctrl.fpu_en = 1'b1;
        end
        default: begin
          ctrl.a2src = 1'b1; ctrl.regwrite = 1'b1; ctrl.resmux = RES_UNIT;
          ctrl.crypto_en = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered main-decode stage feeding the ID/EX control register; FPU/crypto
// ops occupy the register for MC_LAT cycles while upstream is stalled.
module decode_ctrl_stage
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int MC_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [OP_W-1:0] op,
  input  logic            stall_in,
  input  logic            flush,
  output logic            stall_out,
  output logic            out_valid,
  output logic [1:0]      ALUop,
  output logic [1:0]      resmux,
  output logic            ALUSrc,
  output logic            branch,
  output logic            memwrite,
  output logic            a2src,
  output logic            regwrite,
  output logic            jump,
  output logic            fpu_en,
  output logic            crypto_en,
  output logic            mc_start,
  output logic            illegal
);

  localparam int CNT_W = $clog2(MC_LAT + 1);

  ctrl_t            dec, ctrl_q;
  logic             dec_ill;
  logic             vld_q, ill_q, mcs_q;
  mc_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             busy, capture, mc_cap;

  ctrl_decode_comb #(.OP_W(OP_W)) u_dec (
    .op      (op),
    .ctrl    (dec),
    .illegal (dec_ill)
  );

  assign busy    = (state == S_BUSY);
  assign capture = !flush && !stall_in && !busy;
  assign mc_cap  = capture && in_valid && (dec.fpu_en || dec.crypto_en);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (flush) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
    end else if (stall_in) begin
      state_nx = state;
    end else if (busy) begin
      cnt_nx = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) state_nx = S_IDLE;
    end else if (mc_cap && (MC_LAT > 1)) begin
      // first occupancy cycle is the capture itself, so MC_LAT-1 remain
      state_nx = S_BUSY;
      cnt_nx   = CNT_W'(MC_LAT - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_BUBBLE;
      vld_q  <= 1'b0;
      ill_q  <= 1'b0;
      mcs_q  <= 1'b0;
    end else if (flush) begin
      ctrl_q <= CTRL_BUBBLE;
      vld_q  <= 1'b0;
      ill_q  <= 1'b0;
      mcs_q  <= 1'b0;
    end else if (!capture) begin
      mcs_q <= 1'b0;
    end else begin
      ctrl_q <= in_valid ? dec : CTRL_BUBBLE;
      vld_q  <= in_valid;
      ill_q  <= in_valid && dec_ill;
      mcs_q  <= mc_cap;
    end
  end

  assign stall_out = stall_in | busy;
  assign out_valid = vld_q;
  assign ALUop     = ctrl_q.aluop;
  assign resmux    = ctrl_q.resmux;
  assign ALUSrc    = ctrl_q.alusrc;
  assign branch    = ctrl_q.branch;
  assign memwrite  = ctrl_q.memwrite;
  assign a2src     = ctrl_q.a2src;
  assign regwrite  = ctrl_q.regwrite;
  assign jump      = ctrl_q.jump;
  assign fpu_en    = ctrl_q.fpu_en;
  assign crypto_en = ctrl_q.crypto_en;
  assign mc_start  = mcs_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench: dut_a (OP_W=4, MC_LAT=4) covers decode/busy/flush,
// dut_b (OP_W=5, MC_LAT=1) covers the single-cycle unit op and upper-bit illegal.
module tb_decode_ctrl_stage;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, stall_in = 1'b0, flush = 1'b0;
  logic [4:0] op = '0;

  logic       a_stall_out, a_out_valid, a_alusrc, a_branch, a_memwrite, a_a2src;
  logic       a_regwrite, a_jump, a_fpu_en, a_crypto_en, a_mc_start, a_illegal;
  logic [1:0] a_aluop, a_resmux;
  logic       b_stall_out, b_out_valid, b_alusrc, b_branch, b_memwrite, b_a2src;
  logic       b_regwrite, b_jump, b_fpu_en, b_crypto_en, b_mc_start, b_illegal;
  logic [1:0] b_aluop, b_resmux;
  logic [11:0] obs_a, obs_b;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  decode_ctrl_stage #(.OP_W(4), .MC_LAT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op[3:0]),
    .stall_in(stall_in), .flush(flush), .stall_out(a_stall_out),
    .out_valid(a_out_valid), .ALUop(a_aluop), .resmux(a_resmux),
    .ALUSrc(a_alusrc), .branch(a_branch), .memwrite(a_memwrite), .a2src(a_a2src),
    .regwrite(a_regwrite), .jump(a_jump), .fpu_en(a_fpu_en),
    .crypto_en(a_crypto_en), .mc_start(a_mc_start), .illegal(a_illegal)
  );

  decode_ctrl_stage #(.OP_W(5), .MC_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op),
    .stall_in(stall_in), .flush(flush), .stall_out(b_stall_out),
    .out_valid(b_out_valid), .ALUop(b_aluop), .resmux(b_resmux),
    .ALUSrc(b_alusrc), .branch(b_branch), .memwrite(b_memwrite), .a2src(b_a2src),
    .regwrite(b_regwrite), .jump(b_jump), .fpu_en(b_fpu_en),
    .crypto_en(b_crypto_en), .mc_start(b_mc_start), .illegal(b_illegal)
  );

  assign obs_a = {a_aluop, a_alusrc, a_branch, a_memwrite, a_a2src, a_regwrite,
                  a_resmux, a_jump, a_fpu_en, a_crypto_en};
  assign obs_b = {b_aluop, b_alusrc, b_branch, b_memwrite, b_a2src, b_regwrite,
                  b_resmux, b_jump, b_fpu_en, b_crypto_en};

  // {ALUop, ALUSrc,branch,memwrite,a2src,regwrite, resmux, jump,fpu_en,crypto_en}
  function automatic logic [11:0] exp_ctrl(input int o);
    case (o)
      0: exp_ctrl = {2'b10, 5'b00011, 2'b00, 3'b000};
      1: exp_ctrl = {2'b00, 5'b10001, 2'b01, 3'b000};
      2: exp_ctrl = {2'b00, 5'b10100, 2'b01, 3'b000};
      3: exp_ctrl = {2'b10, 5'b10001, 2'b00, 3'b000};
      4: exp_ctrl = {2'b01, 5'b01000, 2'b10, 3'b000};
      5: exp_ctrl = {2'b00, 5'b00001, 2'b10, 3'b100};
      6: exp_ctrl = {2'b00, 5'b00011, 2'b11, 3'b010};
      7: exp_ctrl = {2'b00, 5'b00011, 2'b11, 3'b001};
      default: exp_ctrl = 12'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k = 0;
    in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    while (a_stall_out && k < 20) begin step(); k++; end
    n_cmp++; if (a_stall_out !== 1'b0) begin n_err++; $display("FAIL drain_timeout stall_out=%b want 0", a_stall_out); end
  endtask

  task automatic test_reset();
    logic s;
    step(); step();
    n_cmp++; if (obs_a !== 12'd0) begin n_err++; $display("FAIL reset_ctrl got=%b want=0", obs_a); end
    n_cmp++; if ({a_out_valid, a_illegal, a_mc_start, a_stall_out} !== 4'b0) begin n_err++; $display("FAIL reset_flags got=%b want=0000", {a_out_valid, a_illegal, a_mc_start, a_stall_out}); end
    rst_n = 1'b1;
    in_valid = 1'b1; op = 5'd6; step();
    n_cmp++; if (a_stall_out !== 1'b1) begin n_err++; $display("FAIL reset_prebusy stall_out=%b want 1", a_stall_out); end
    #2;
    s = 1'($urandom_range(0, 1));
    stall_in = s; flush = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1));
    op = 5'($urandom_range(0, 31)); rst_n = 1'b0; #1;
    n_cmp++; if (obs_a !== 12'd0) begin n_err++; $display("FAIL async_reset_ctrl got=%b want=0", obs_a); end
    n_cmp++; if ({a_out_valid, a_illegal, a_mc_start} !== 3'b0) begin n_err++; $display("FAIL async_reset_flags got=%b want=000", {a_out_valid, a_illegal, a_mc_start}); end
    n_cmp++; if (a_stall_out !== s) begin n_err++; $display("FAIL async_reset_stall got=%b want=%b", a_stall_out, s); end
    stall_in = ~s; #1;
    n_cmp++; if (a_stall_out !== ~s) begin n_err++; $display("FAIL async_reset_stall2 got=%b want=%b", a_stall_out, ~s); end
    @(posedge clk); #1;
    in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0; op = '0; rst_n = 1'b1;
    step();
    n_cmp++; if ({a_stall_out, a_out_valid} !== 2'b00) begin n_err++; $display("FAIL reset_release got=%b want=00", {a_stall_out, a_out_valid}); end
  endtask

  task automatic test_decode();
    for (int o = 0; o < 8; o++) begin
      in_valid = 1'b1; op = 5'(o); step();
      n_cmp++; if (obs_a !== exp_ctrl(o)) begin n_err++; $display("FAIL decode_op%0d got=%b want=%b", o, obs_a, exp_ctrl(o)); end
      n_cmp++; if ({a_out_valid, a_illegal} !== 2'b10) begin n_err++; $display("FAIL decode_vld_op%0d got=%b want=10", o, {a_out_valid, a_illegal}); end
      n_cmp++; if (a_mc_start !== (o >= 6)) begin n_err++; $display("FAIL decode_mcs_op%0d got=%b want=%b", o, a_mc_start, (o >= 6)); end
      drain();
    end
    in_valid = 1'b1; op = 5'd9; step();
    n_cmp++; if (obs_a !== 12'd0) begin n_err++; $display("FAIL illegal_ctrl got=%b want=0", obs_a); end
    n_cmp++; if ({a_out_valid, a_illegal, a_stall_out, a_mc_start} !== 4'b1100) begin n_err++; $display("FAIL illegal_flags got=%b want=1100", {a_out_valid, a_illegal, a_stall_out, a_mc_start}); end
    in_valid = 1'b0; step();
    n_cmp++; if ({a_out_valid, a_illegal} !== 2'b00) begin n_err++; $display("FAIL bubble_flags got=%b want=00", {a_out_valid, a_illegal}); end
  endtask

  task automatic test_mc_fpu();
    int nst = 0, nmc = 0;
    in_valid = 1'b1; op = 5'd6; step();
    op = 5'd0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (obs_a !== exp_ctrl(6)) begin n_err++; $display("FAIL fpu_hold_c%0d got=%b want=%b", c, obs_a, exp_ctrl(6)); end
      n_cmp++; if (a_stall_out !== (c < 3)) begin n_err++; $display("FAIL fpu_stall_c%0d got=%b want=%b", c, a_stall_out, (c < 3)); end
      nst += int'(a_stall_out); nmc += int'(a_mc_start);
      step();
    end
    n_cmp++; if (nst !== 3) begin n_err++; $display("FAIL fpu_stall_count got=%0d want=3", nst); end
    n_cmp++; if (nmc !== 1) begin n_err++; $display("FAIL fpu_mcs_count got=%0d want=1", nmc); end
    n_cmp++; if ({obs_a, a_out_valid} !== {exp_ctrl(0), 1'b1}) begin n_err++; $display("FAIL fpu_queued_op0 got=%b want=%b", {obs_a, a_out_valid}, {exp_ctrl(0), 1'b1}); end
    in_valid = 1'b0; step();
  endtask

  task automatic test_stall_busy();
    int nst = 0;
    in_valid = 1'b1; op = 5'd7; step();
    in_valid = 1'b0;
    for (int e = 0; e < 7; e++) begin
      n_cmp++; if (a_crypto_en !== (e <= 5)) begin n_err++; $display("FAIL crypto_hold_e%0d got=%b want=%b", e, a_crypto_en, (e <= 5)); end
      n_cmp++; if (a_stall_out !== (e <= 4)) begin n_err++; $display("FAIL crypto_stall_e%0d got=%b want=%b", e, a_stall_out, (e <= 4)); end
      n_cmp++; if (a_mc_start !== (e == 0)) begin n_err++; $display("FAIL crypto_mcs_e%0d got=%b want=%b", e, a_mc_start, (e == 0)); end
      nst += int'(a_stall_out);
      stall_in = (e == 1 || e == 2);
      step();
    end
    n_cmp++; if (nst !== 5) begin n_err++; $display("FAIL crypto_stall_count got=%0d want=5", nst); end
    stall_in = 1'b0;
  endtask

  task automatic test_flush_busy();
    in_valid = 1'b1; op = 5'd6; step();
    in_valid = 1'b0; step();
    flush = 1'b1; step();
    n_cmp++; if (obs_a !== 12'd0) begin n_err++; $display("FAIL flush_ctrl got=%b want=0", obs_a); end
    n_cmp++; if ({a_out_valid, a_illegal, a_mc_start, a_stall_out} !== 4'b0) begin n_err++; $display("FAIL flush_flags got=%b want=0000", {a_out_valid, a_illegal, a_mc_start, a_stall_out}); end
    flush = 1'b0; in_valid = 1'b1; op = 5'd3; step();
    n_cmp++; if ({obs_a, a_out_valid, a_stall_out} !== {exp_ctrl(3), 2'b10}) begin n_err++; $display("FAIL flush_next_op3 got=%b want=%b", {obs_a, a_out_valid, a_stall_out}, {exp_ctrl(3), 2'b10}); end
    in_valid = 1'b0; step();
  endtask

  task automatic test_flush_stall();
    in_valid = 1'b1; op = 5'd4; step();
    in_valid = 1'b0; stall_in = 1'b1; step();
    n_cmp++; if ({obs_a, a_out_valid, a_stall_out} !== {exp_ctrl(4), 2'b11}) begin n_err++; $display("FAIL stall_hold_op4 got=%b want=%b", {obs_a, a_out_valid, a_stall_out}, {exp_ctrl(4), 2'b11}); end
    flush = 1'b1; step();
    n_cmp++; if ({obs_a, a_out_valid, a_stall_out} !== {12'd0, 2'b01}) begin n_err++; $display("FAIL flush_over_stall got=%b want=%b", {obs_a, a_out_valid, a_stall_out}, {12'd0, 2'b01}); end
    flush = 1'b0; stall_in = 1'b0; step();
    in_valid = 1'b1; op = 5'd6; step();
    n_cmp++; if ({b_mc_start, b_stall_out, b_fpu_en, b_resmux} !== 5'b10111) begin n_err++; $display("FAIL lat1_first got=%b want=10111", {b_mc_start, b_stall_out, b_fpu_en, b_resmux}); end
    step();
    n_cmp++; if ({b_mc_start, b_stall_out, b_out_valid} !== 3'b101) begin n_err++; $display("FAIL lat1_b2b got=%b want=101", {b_mc_start, b_stall_out, b_out_valid}); end
    in_valid = 1'b0; step();
    n_cmp++; if ({b_mc_start, b_out_valid} !== 2'b00) begin n_err++; $display("FAIL lat1_bubble got=%b want=00", {b_mc_start, b_out_valid}); end
    drain();
    in_valid = 1'b1; op = 5'b10110; step();
    n_cmp++; if ({obs_b, b_out_valid, b_illegal, b_mc_start} !== {12'd0, 3'b110}) begin n_err++; $display("FAIL upper_bit_illegal got=%b want=%b", {obs_b, b_out_valid, b_illegal, b_mc_start}, {12'd0, 3'b110}); end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_mc_fpu();
    test_stall_busy();
    test_flush_busy();
    test_flush_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
